// File: rtl/sync_fifo_ctrl.sv
// Pointer/status controller for a show-ahead FIFO built on an external async-read dual-port RAM.
// Optional sticky overflow/underflow flags are enabled with `define FIFO_CTRL_ERR_FLAG_EN.
module sync_fifo_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_LEVEL   = 14,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic                  i_pop,
`ifdef FIFO_CTRL_ERR_FLAG_EN
  input  logic                  i_err_clr,
  output logic                  o_overflow,
  output logic                  o_underflow,
`endif
  output logic                  o_ram_wr_en,
  output logic [ADDR_WIDTH-1:0] o_ram_wr_addr,
  output logic                  o_ram_rd_en,
  output logic [ADDR_WIDTH-1:0] o_ram_rd_addr,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [ADDR_WIDTH:0]   o_data_count
);

  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [CW-1:0] AfLevel = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AeLevel = CW'(AE_LEVEL);
  localparam logic [CW-1:0] DepthC  = CW'(DEPTH);

  logic [CW-1:0] r_wr_ptr;
  logic [CW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_almost_full;
  logic          r_almost_empty;

  logic          w_wr_acc;
  logic          w_rd_acc;
  logic [CW-1:0] w_wr_ptr_d;
  logic [CW-1:0] w_rd_ptr_d;
  logic [CW-1:0] w_count_d;
  logic          w_full_d;
  logic          w_empty_d;
  logic          w_almost_full_d;
  logic          w_almost_empty_d;

  always_comb begin
    // Requests are masked during reset so the RAM is never written while state is cleared.
    w_wr_acc   = i_rst_n & i_push & ~r_full;
    w_rd_acc   = i_rst_n & i_pop & ~r_empty;
    w_wr_ptr_d = r_wr_ptr + CW'(w_wr_acc);
    w_rd_ptr_d = r_rd_ptr + CW'(w_rd_acc);
    w_count_d  = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);

    // Full/empty come from the wrap-bit decode of the next pointers.
    w_full_d         = (w_wr_ptr_d[ADDR_WIDTH-1:0] == w_rd_ptr_d[ADDR_WIDTH-1:0]) &&
                       (w_wr_ptr_d[ADDR_WIDTH] != w_rd_ptr_d[ADDR_WIDTH]);
    w_empty_d        = (w_wr_ptr_d == w_rd_ptr_d);
    w_almost_full_d  = (w_count_d >= AfLevel);
    w_almost_empty_d = (w_count_d <= AeLevel);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_wr_ptr       <= w_wr_ptr_d;
      r_rd_ptr       <= w_rd_ptr_d;
      r_count        <= w_count_d;
      r_full         <= w_full_d;
      r_empty        <= w_empty_d;
      r_almost_full  <= w_almost_full_d;
      r_almost_empty <= w_almost_empty_d;
    end
  end

`ifdef FIFO_CTRL_ERR_FLAG_EN
  logic r_overflow;
  logic r_underflow;
  logic w_overflow_d;
  logic w_underflow_d;

  always_comb begin
    // A new error wins over a simultaneous clear.
    w_overflow_d  = (i_push & r_full) | (r_overflow & ~i_err_clr);
    w_underflow_d = (i_pop & r_empty) | (r_underflow & ~i_err_clr);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_overflow_d;
      r_underflow <= w_underflow_d;
    end
  end

  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
`endif

  assign o_ram_wr_en    = w_wr_acc;
  assign o_ram_rd_en    = w_rd_acc;
  assign o_ram_wr_addr  = r_wr_ptr[ADDR_WIDTH-1:0];
  assign o_ram_rd_addr  = r_rd_ptr[ADDR_WIDTH-1:0];
  assign o_full         = r_full;
  assign o_empty        = r_empty;
  assign o_almost_full  = r_almost_full;
  assign o_almost_empty = r_almost_empty;
  assign o_data_count   = r_count;

  logic unused_depth;
  assign unused_depth = ^DepthC;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: queue-based reference model plus directed literal checks.
module tb_sync_fifo_ctrl;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 14;
  localparam int unsigned AE    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   data_count;
`ifdef FIFO_CTRL_ERR_FLAG_EN
  logic          err_clr = 1'b0;
  logic          overflow;
  logic          underflow;
`endif

  logic [7:0] mem [DEPTH];
  logic [7:0] rd_data;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0]  q[$];
  int unsigned wr_cnt = 0;
  int unsigned rd_cnt = 0;
  bit          mdl_valid = 1'b0;
  bit          ov_exp = 1'b0;
  bit          un_exp = 1'b0;

  sync_fifo_ctrl #(
    .ADDR_WIDTH(AW),
    .AF_LEVEL  (AF),
    .AE_LEVEL  (AE)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_push        (push),
    .i_pop         (pop),
`ifdef FIFO_CTRL_ERR_FLAG_EN
    .i_err_clr     (err_clr),
    .o_overflow    (overflow),
    .o_underflow   (underflow),
`endif
    .o_ram_wr_en   (ram_wr_en),
    .o_ram_wr_addr (ram_wr_addr),
    .o_ram_rd_en   (ram_rd_en),
    .o_ram_rd_addr (ram_rd_addr),
    .o_full        (full),
    .o_empty       (empty),
    .o_almost_full (almost_full),
    .o_almost_empty(almost_empty),
    .o_data_count  (data_count)
  );

  always #5 clk = ~clk;

  // Behavioural async-read RAM
  always @(posedge clk) if (ram_wr_en) mem[ram_wr_addr] <= wr_data;
  assign rd_data = mem[ram_rd_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, then the model advances for the coming edge.
  always @(negedge clk) begin
    int unsigned sz;
    bit acc_w, acc_r;
    sz = q.size();
    if (mdl_valid) begin
      chk("ram_wr_en", 32'(ram_wr_en), 32'(rst_n && push && sz < DEPTH));
      chk("ram_rd_en", 32'(ram_rd_en), 32'(rst_n && pop && sz > 0));
      chk("ram_wr_addr", 32'(ram_wr_addr), wr_cnt % DEPTH);
      chk("ram_rd_addr", 32'(ram_rd_addr), rd_cnt % DEPTH);
      chk("full", 32'(full), 32'(sz == DEPTH));
      chk("empty", 32'(empty), 32'(sz == 0));
      chk("almost_full", 32'(almost_full), 32'(sz >= AF));
      chk("almost_empty", 32'(almost_empty), 32'(sz <= AE));
      chk("data_count", 32'(data_count), sz);
      if (sz > 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
`ifdef FIFO_CTRL_ERR_FLAG_EN
      chk("overflow", 32'(overflow), 32'(ov_exp));
      chk("underflow", 32'(underflow), 32'(un_exp));
`endif
    end
    if (!rst_n) begin
      q.delete();
      wr_cnt = 0;
      rd_cnt = 0;
      ov_exp = 1'b0;
      un_exp = 1'b0;
      mdl_valid = 1'b1;
    end else if (mdl_valid) begin
      acc_w = push && sz < DEPTH;
      acc_r = pop && sz > 0;
`ifdef FIFO_CTRL_ERR_FLAG_EN
      ov_exp = (push && sz == DEPTH) || (ov_exp && !err_clr);
      un_exp = (pop && sz == 0) || (un_exp && !err_clr);
`endif
      if (acc_r) begin
        void'(q.pop_front());
        rd_cnt++;
      end
      if (acc_w) begin
        q.push_back(wr_data);
        wr_cnt++;
      end
    end
  end

  task automatic step(input logic p, input logic r, input logic [7:0] d);
    push = p;
    pop = r;
    wr_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned bias;
    rst_n = 1'b0;
    repeat (2) step(1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 8'h00);

    // Reset state
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_data_count", 32'(data_count), 32'd0);
    chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
    chk("rst_rd_addr", 32'(ram_rd_addr), 32'd0);

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i));
      if (i == 1)  chk("ae_at_2", 32'(almost_empty), 32'd1);
      if (i == 2)  chk("ae_at_3", 32'(almost_empty), 32'd0);
      if (i == 12) chk("af_at_13", 32'(almost_full), 32'd0);
      if (i == 13) chk("af_at_14", 32'(almost_full), 32'd1);
      if (i == 14) chk("full_at_15", 32'(full), 32'd0);
      if (i == 15) chk("full_at_16", 32'(full), 32'd1);
    end
    chk("count_16", 32'(data_count), 32'd16);

    // Push while full is dropped
    push = 1'b1;
    #1;
    chk("push_full_wr_en", 32'(ram_wr_en), 32'd0);
    step(1'b1, 1'b0, 8'hEE);
    chk("push_full_count", 32'(data_count), 32'd16);
    chk("push_full_wr_addr", 32'(ram_wr_addr), 32'd0);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", 32'(rd_data), 32'(i));
      step(1'b0, 1'b1, 8'h00);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    pop = 1'b1;
    #1;
    chk("pop_empty_rd_en", 32'(ram_rd_en), 32'd0);
    step(1'b0, 1'b1, 8'h00);
    chk("pop_empty_count", 32'(data_count), 32'd0);

    // Wrap-around
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) begin
      push = 1'b1;
      #1;
      chk("wrap_wr_addr", 32'(ram_wr_addr), 32'((10 + i) % 16));
      step(1'b1, 1'b0, 8'(8'h40 + i));
    end
    chk("wrap_full", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("wrap_order", 32'(rd_data), 32'(8'h40 + i));
      step(1'b0, 1'b1, 8'h00);
    end

    // Simultaneous push+pop at count 5, at full, at empty
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
    step(1'b1, 1'b1, 8'h70);
    chk("sim_mid_count", 32'(data_count), 32'd5);
    chk("sim_mid_head", 32'(rd_data), 32'h61);
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
    chk("sim_pre_full", 32'(full), 32'd1);
    step(1'b1, 1'b1, 8'h7F);
    chk("sim_full_count", 32'(data_count), 32'd15);
    chk("sim_full_flag", 32'(full), 32'd0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'h00);
    chk("sim_pre_empty", 32'(empty), 32'd1);
    step(1'b1, 1'b1, 8'hA5);
    chk("sim_empty_count", 32'(data_count), 32'd1);
    chk("sim_empty_data", 32'(rd_data), 32'hA5);
    step(1'b0, 1'b1, 8'h00);

`ifdef FIFO_CTRL_ERR_FLAG_EN
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i));
    step(1'b1, 1'b0, 8'hFF);
    chk("overflow_set", 32'(overflow), 32'd1);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("overflow_hold", 32'(overflow), 32'd1);
    err_clr = 1'b1;
    step(1'b1, 1'b0, 8'hFF);
    chk("overflow_clr_vs_new", 32'(overflow), 32'd1);
    step(1'b0, 1'b0, 8'h00);
    err_clr = 1'b0;
    chk("overflow_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    chk("underflow_set", 32'(underflow), 32'd1);
    err_clr = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    err_clr = 1'b0;
    chk("underflow_cleared", 32'(underflow), 32'd0);
`endif

    // Reset mid-fill
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
    rst_n = 1'b0;
    push = 1'b1;
    #1;
    chk("rst_masks_push", 32'(ram_wr_en), 32'd0);
    step(1'b1, 1'b0, 8'hCC);
    rst_n = 1'b1;
    chk("midrst_count", 32'(data_count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_wr_addr", 32'(ram_wr_addr), 32'd0);

    // Randomized traffic with changing fill bias and rare resets
    bias = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) bias = $urandom_range(15, 85);
      rst_n = ($urandom_range(0, 499) != 0);
`ifdef FIFO_CTRL_ERR_FLAG_EN
      err_clr = ($urandom_range(0, 7) == 0);
`endif
      step(($urandom_range(0, 99) < bias), ($urandom_range(0, 99) >= bias),
           8'($urandom_range(0, 255)));
    end
    rst_n = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
